// File: rtl/regwb_pkg.sv
// Shared constants for the register-file write-back path: register file geometry,
// the hard-wired zero register and the fixed requester slot assignments.
package regwb_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 64;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 6'd0;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_IO   = 2;

endpackage

// File: rtl/regwb_rr_arbiter.sv
// Combinational round-robin arbiter: scans requests starting at ptr, wrapping
// modulo NUM_REQ, and returns a one-hot grant plus its encoded index.
module regwb_rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // One extra bit holds ptr + i before the wrap back into range.
      sum = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (en && !found && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: round-robin grant
// into a one-entry output stage. Define REGWB_SCOREBOARD_EN for the busy-bit scoreboard.
module regfile_wb_arbiter
  import regwb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_write,
  output logic [ADDR_W-1:0]         rf_addr,
  output logic [DATA_W-1:0]         rf_data,
  input  logic                      rf_ready,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_addr,
  input  logic [ADDR_W-1:0]         qry_addr_a,
  input  logic [ADDR_W-1:0]         qry_addr_b,
  output logic                      qry_busy_a,
  output logic                      qry_busy_b
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic               out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]  rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]  rf_data_q, rf_data_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               stage_free, grant, commit;

  assign stage_free = !out_valid_q || rf_ready;
  assign grant      = |gnt;
  assign commit     = out_valid_q && rf_ready && (rf_addr_q != ZERO_ADDR);

  // Reset gates the enable so no requester sees a handshake that reset discards.
  regwb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (stage_free && !Reset),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign rf_write  = out_valid_q && (rf_addr_q != ZERO_ADDR);
  assign rf_addr   = rf_addr_q;
  assign rf_data   = rf_data_q;

  always_comb begin
    out_valid_d = out_valid_q;
    rf_addr_d   = rf_addr_q;
    rf_data_d   = rf_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant) begin
      out_valid_d = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          rf_addr_d = req_addr[i*ADDR_W +: ADDR_W];
          rf_data_d = req_data[i*DATA_W +: DATA_W];
        end
      end
      rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (rf_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments; reset is synchronous and
  // active-high, sampled only on the rising clock edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

`ifdef REGWB_SCOREBOARD_EN
  logic [2**ADDR_W-1:0] busy_q, busy_d;

  // Clear is applied first so a same-cycle reservation of that address wins.
  always_comb begin
    busy_d = busy_q;
    if (commit) busy_d[rf_addr_q] = 1'b0;
    if (rsv_valid && (rsv_addr != ZERO_ADDR)) busy_d[rsv_addr] = 1'b1;
  end

  // NOTE: the busy array is reset on purpose: a reset drops the pending write,
  // so any reservation left set would stall issue forever.
  always_ff @(posedge Clock) begin
    if (Reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign qry_busy_a = (qry_addr_a != ZERO_ADDR) && busy_q[qry_addr_a];
  assign qry_busy_b = (qry_addr_b != ZERO_ADDR) && busy_q[qry_addr_b];
`else
  logic unused_sb;
  assign unused_sb  = &{1'b0, rsv_valid, rsv_addr, qry_addr_a, qry_addr_b, commit};
  assign qry_busy_a = 1'b0;
  assign qry_busy_b = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a negedge monitor keeps a scoreboard of
// granted writes and matches them against committed register-file writes.
module tb_regfile_wb_arbiter;
  import regwb_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int AW      = REG_ADDR_W;
  localparam int DW      = REG_DATA_W;
`ifdef REGWB_SCOREBOARD_EN
  localparam logic SB_EN = 1'b1;
`else
  localparam logic SB_EN = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid, req_ready;
  logic [NUM_REQ*AW-1:0]  req_addr;
  logic [NUM_REQ*DW-1:0]  req_data;
  logic                   rf_write, rf_ready;
  logic [AW-1:0]          rf_addr;
  logic [DW-1:0]          rf_data;
  logic                   rsv_valid;
  logic [AW-1:0]          rsv_addr, qry_addr_a, qry_addr_b;
  logic                   qry_busy_a, qry_busy_b;

  int  passed = 0;
  int  total  = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DW), .ADDR_W(AW)) dut (
    .Clock(clk), .Reset(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data), .rf_ready(rf_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .qry_addr_a(qry_addr_a), .qry_addr_b(qry_addr_b),
    .qry_busy_a(qry_busy_a), .qry_busy_b(qry_busy_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Scoreboard: commits pop first (current stage), then this cycle's grant is pushed.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      exp_q.delete();
    end else begin
      if (rf_write === 1'b1 && rf_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("commit_unexpected", 64'(rf_addr), 64'hFFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("commit_addr", 64'(rf_addr), 64'(e.addr));
          check("commit_data", 64'(rf_data), 64'(e.data));
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] === 1'b1 && req_addr[i*AW +: AW] != ZERO_REG)
          exp_q.push_back('{addr: req_addr[i*AW +: AW], data: req_data[i*DW +: DW]});
      end
    end
  end

  initial begin
    int ord_a[6];
    int ord_b[6];
    ord_a = '{1, 2, 0, 1, 2, 0};
    ord_b = '{0, 1, 2, 0, 1, 2};
    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; rf_ready = 1'b1;
    rsv_valid = 1'b0; rsv_addr = '0; qry_addr_a = '0; qry_addr_b = '0;

    // Reset state
    req_valid = 3'b111;
    #1 check("ready_in_reset", 64'(req_ready), 64'h0);
    cyc(); cyc();
    req_valid = '0;
    rst = 1'b0;
    check("rst_rf_write", 64'(rf_write), 64'h0);
    check("rst_rf_addr", 64'(rf_addr), 64'h0);
    check("rst_rf_data", 64'(rf_data), 64'h0);
    check("rst_ready", 64'(req_ready), 64'h0);

    // Single ALU write
    set_req(REQ_ALU, 6'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    #1 check("alu_ready", 64'(req_ready), 64'h1);
    cyc();
    req_valid = '0;
    check("alu_rf_write", 64'(rf_write), 64'h1);
    check("alu_rf_addr", 64'(rf_addr), 64'h5);
    check("alu_rf_data", 64'(rf_data), 64'hDEADBEEF);
    cyc();
    check("alu_drop", 64'(rf_write), 64'h0);

    // All requesters valid: pointer sits at 1 after the ALU grant
    set_req(REQ_ALU, 6'd10, 32'hA0);
    set_req(REQ_LOAD, 6'd11, 32'hA1);
    set_req(REQ_IO, 6'd12, 32'hA2);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1 check("rr_order_a", 64'(req_ready), 64'(3'b001 << ord_a[k]));
      cyc();
    end
    req_valid = '0;
    cyc(); cyc();

    // Write to register 0 occupies the stage without a register-file write
    set_req(REQ_LOAD, 6'd0, 32'h1234);
    req_valid = 3'b010;
    #1 check("zero_ready", 64'(req_ready), 64'h2);
    cyc();
    req_valid = '0;
    check("zero_rf_write", 64'(rf_write), 64'h0);
    check("zero_rf_addr", 64'(rf_addr), 64'h0);
    check("zero_rf_data", 64'(rf_data), 64'h1234);
    cyc();

    // Back-pressure: stage holds, no ready, then commit and regrant together
    rf_ready = 1'b0;
    set_req(REQ_ALU, 6'd20, 32'h55);
    req_valid = 3'b001;
    #1 check("stall_first_ready", 64'(req_ready), 64'h1);
    cyc();
    set_req(REQ_IO, 6'd21, 32'h66);
    req_valid = 3'b100;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("stall_ready", 64'(req_ready), 64'h0);
      check("stall_addr", 64'(rf_addr), 64'd20);
      check("stall_data", 64'(rf_data), 64'h55);
      cyc();
    end
    rf_ready = 1'b1;
    #1 check("stall_regrant", 64'(req_ready), 64'h4);
    cyc();
    req_valid = '0;
    check("stall_next_addr", 64'(rf_addr), 64'd21);
    cyc();

    // Scoreboard: reserve, no bypass, clear on commit, set wins over clear
    rsv_valid = 1'b1; rsv_addr = 6'd7; qry_addr_a = 6'd7; qry_addr_b = 6'd0;
    #1 check("sb_no_bypass", 64'(qry_busy_a), 64'h0);
    cyc();
    rsv_valid = 1'b0;
    check("sb_set7", 64'(qry_busy_a), 64'(SB_EN));
    rsv_valid = 1'b1; rsv_addr = 6'd0;
    cyc();
    rsv_valid = 1'b0;
    check("sb_zero_reg", 64'(qry_busy_b), 64'h0);
    set_req(REQ_ALU, 6'd7, 32'h77);
    req_valid = 3'b001;
    cyc();
    req_valid = '0;
    check("sb_pending7", 64'(qry_busy_a), 64'(SB_EN));
    cyc();
    check("sb_clear7", 64'(qry_busy_a), 64'h0);
    rsv_valid = 1'b1; rsv_addr = 6'd7;
    cyc();
    rsv_valid = 1'b0;
    set_req(REQ_ALU, 6'd7, 32'h78);
    req_valid = 3'b001;
    cyc();
    req_valid = '0;
    rsv_valid = 1'b1; rsv_addr = 6'd7;
    cyc();
    rsv_valid = 1'b0;
    check("sb_set_wins", 64'(qry_busy_a), 64'(SB_EN));

    // Reset with a pending write and busy[9] set
    rsv_valid = 1'b1; rsv_addr = 6'd9; qry_addr_a = 6'd9;
    cyc();
    rsv_valid = 1'b0;
    check("sb_set9", 64'(qry_busy_a), 64'(SB_EN));
    rf_ready = 1'b0;
    set_req(REQ_ALU, 6'd9, 32'h99);
    req_valid = 3'b001;
    cyc();
    req_valid = '0;
    check("pre_rst_write", 64'(rf_write), 64'h1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_write", 64'(rf_write), 64'h0);
    check("mid_rst_addr", 64'(rf_addr), 64'h0);
    check("mid_rst_busy9", 64'(qry_busy_a), 64'h0);

    // Pointer back at 0: grants in order 0,1,2,0,1,2
    rf_ready = 1'b1;
    set_req(REQ_ALU, 6'd1, 32'hB0);
    set_req(REQ_LOAD, 6'd2, 32'hB1);
    set_req(REQ_IO, 6'd3, 32'hB2);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1 check("rr_order_b", 64'(req_ready), 64'(3'b001 << ord_b[k]));
      cyc();
    end
    req_valid = '0;
    cyc(); cyc();
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
